// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV32I memory-access stage: bus load/store issue, lane steering, load extract; optional MISALIGN_TRAP_EN
module mem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        mem_op_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       sdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              stall_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t              state_q, state_d;
  logic                store_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          be_q;
  logic [31:0]         swdata_q;
  logic [4:0]          wd_q;
  logic                wreg_q;

  logic                is_mem;
  logic                is_store_in;
  logic [1:0]          size_in;
  logic                trap;
  logic                accept;
  logic                alu_retire;
  logic [3:0]          be_in;
  logic [31:0]         swdata_in;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;

  // Loads and stores share funct3 encodings only for the byte/half/word codes;
  // every unlisted code degenerates to a word access.
  function automatic logic [1:0] acc_size(input logic store, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (store) begin
      case (f3)
        3'b000:  sz = SZ_BYTE;
        3'b001:  sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: sz = SZ_BYTE;
        3'b001, 3'b101: sz = SZ_HALF;
        default:        sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  assign is_mem      = valid_i && (mem_op_i == OP_LOAD || mem_op_i == OP_STORE);
  assign is_store_in = (mem_op_i == OP_STORE);
  assign size_in     = acc_size(is_store_in, funct3_i);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_mem &&
                (((size_in == SZ_HALF) && addr_i[0]) ||
                 ((size_in == SZ_WORD) && (addr_i[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign accept     = (state_q == S_IDLE) && is_mem && !trap;
  assign alu_retire = (state_q == S_IDLE) && valid_i && !is_mem;

  // Store data is replicated across every lane so the bus only needs the enables.
  always_comb begin
    be_in     = 4'b1111;
    swdata_in = sdata_i;
    case (size_in)
      SZ_BYTE: begin
        be_in     = 4'b0001 << addr_i[1:0];
        swdata_in = {4{sdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_in     = addr_i[1] ? 4'b1100 : 4'b0011;
        swdata_in = {2{sdata_i[15:0]}};
      end
      default: begin
        be_in     = 4'b1111;
        swdata_in = sdata_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: ld_byte = mem_rdata_i[7:0];
      2'd1: ld_byte = mem_rdata_i[15:8];
      2'd2: ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Stall falls in the completion cycle so upstream advances exactly once per op.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          stall_o = 1'b1;
        end
      end
      S_REQ: begin
        stall_o = !(mem_gnt_i && store_q);
        if (mem_gnt_i) begin
          state_d = store_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_o = !mem_rvalid_i;
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = mem_req_o && store_q;
  assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
  assign mem_wdata_o = mem_req_o ? swdata_q : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      swdata_q <= 32'h0;
      wd_q     <= 5'd0;
      wreg_q   <= 1'b0;
      wd_o     <= 5'd0;
      wreg_o   <= 1'b0;
      wdata_o  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wreg_o  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o <= trap && (state_q == S_IDLE);
`endif
      if (accept) begin
        store_q  <= is_store_in;
        funct3_q <= funct3_i;
        addr_q   <= addr_i;
        be_q     <= be_in;
        swdata_q <= swdata_in;
        wd_q     <= wd_i;
        wreg_q   <= wreg_i;
      end
      if (alu_retire) begin
        wd_o    <= wd_i;
        wreg_o  <= wreg_i && (wd_i != 5'd0);
        wdata_o <= wdata_i;
      end
      if (state_q == S_WAIT && mem_rvalid_i) begin
        wd_o    <= wd_q;
        wreg_o  <= wreg_q && (wd_q != 5'd0);
        wdata_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
`timescale 1ns/1ps
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [1:0]  mem_op_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] sdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .sdata_i(sdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .stall_o(stall_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0; mem_op_i = 0; funct3_i = 0;
    addr_i = 0; sdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL rst_wreg got=%b exp=0", wreg_o); end
    checks++; if (wd_o !== 5'd0) begin failures++; $display("FAIL rst_wd got=%0d exp=0", wd_o); end
    checks++; if (wdata_o !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req_o); end
    checks++; if (mem_be_o !== 4'h0) begin failures++; $display("FAIL rst_be got=%b exp=0000", mem_be_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
  endtask

  task automatic test_alu(input logic [4:0] wd, input logic [31:0] wdata, input logic exp_wreg);
    valid_i = 1; mem_op_i = 2'b00; wd_i = wd; wreg_i = 1; wdata_i = wdata;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_o); end
    tick();
    valid_i = 0; #1;
    checks++; if (wd_o !== wd) begin failures++; $display("FAIL alu_wd got=%0d exp=%0d", wd_o, wd); end
    checks++; if (wreg_o !== exp_wreg) begin failures++; $display("FAIL alu_wreg got=%b exp=%b", wreg_o, exp_wreg); end
    checks++; if (wdata_o !== wdata) begin failures++; $display("FAIL alu_wdata got=%h exp=%h", wdata_o, wdata); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall2 got=%b exp=0", stall_o); end
    tick();
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%b exp=0", wreg_o); end
    checks++; if (wdata_o !== wdata) begin failures++; $display("FAIL alu_hold got=%h exp=%h", wdata_o, wdata); end
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd, input int gnt_delay);
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    valid_i = 1; mem_op_i = 2'b10; funct3_i = f3; addr_i = addr; sdata_i = sdata; wd_i = 5'd9; wreg_i = 1;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL st_accept_stall got=%b exp=1", stall_o); end
    tick();
    for (int i = 0; i < gnt_delay; i++) begin
      #1;
      checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL st_req got=%b exp=1", mem_req_o); end
      checks++; if (mem_we_o !== 1'b1) begin failures++; $display("FAIL st_we got=%b exp=1", mem_we_o); end
      checks++; if (mem_addr_o !== exp_addr) begin failures++; $display("FAIL st_addr got=%h exp=%h", mem_addr_o, exp_addr); end
      checks++; if (mem_be_o !== exp_be) begin failures++; $display("FAIL st_be got=%b exp=%b", mem_be_o, exp_be); end
      checks++; if (mem_wdata_o !== exp_wd) begin failures++; $display("FAIL st_wdata got=%h exp=%h", mem_wdata_o, exp_wd); end
      checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL st_wait_stall got=%b exp=1", stall_o); end
      tick();
    end
    mem_gnt_i = 1; #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL st_gnt_stall got=%b exp=0", stall_o); end
    checks++; if (mem_be_o !== exp_be) begin failures++; $display("FAIL st_gnt_be got=%b exp=%b", mem_be_o, exp_be); end
    checks++; if (mem_wdata_o !== exp_wd) begin failures++; $display("FAIL st_gnt_wdata got=%h exp=%h", mem_wdata_o, exp_wd); end
    tick();
    mem_gnt_i = 0; valid_i = 0; #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL st_done_req got=%b exp=0", mem_req_o); end
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL st_wreg got=%b exp=0", wreg_o); end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [4:0] wd, input logic [31:0] exp_data, input int rv_delay);
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    valid_i = 1; mem_op_i = 2'b01; funct3_i = f3; addr_i = addr; wd_i = wd; wreg_i = 1;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ld_accept_stall got=%b exp=1", stall_o); end
    tick();
    mem_gnt_i = 1; #1;
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL ld_req got=%b exp=1", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL ld_we got=%b exp=0", mem_we_o); end
    checks++; if (mem_addr_o !== exp_addr) begin failures++; $display("FAIL ld_addr got=%h exp=%h", mem_addr_o, exp_addr); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ld_gnt_stall got=%b exp=1", stall_o); end
    tick();
    mem_gnt_i = 0;
    for (int i = 0; i < rv_delay; i++) begin
      #1;
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL ld_wait_req got=%b exp=0", mem_req_o); end
      checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ld_wait_stall got=%b exp=1", stall_o); end
      checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL ld_wait_wreg got=%b exp=0", wreg_o); end
      tick();
    end
    mem_rvalid_i = 1; mem_rdata_i = rdata; #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL ld_rv_stall got=%b exp=0", stall_o); end
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0; valid_i = 0; #1;
    checks++; if (wdata_o !== exp_data) begin failures++; $display("FAIL ld_data got=%h exp=%h", wdata_o, exp_data); end
    checks++; if (wd_o !== wd) begin failures++; $display("FAIL ld_wd got=%0d exp=%0d", wd_o, wd); end
    checks++; if (wreg_o !== 1'b1) begin failures++; $display("FAIL ld_wreg got=%b exp=1", wreg_o); end
    tick();
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL ld_pulse got=%b exp=0", wreg_o); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    valid_i = 1; mem_op_i = 2'b01; funct3_i = 3'b010; addr_i = 32'h500; wd_i = 5'd3; wreg_i = 1;
    tick();
    mem_gnt_i = 1; tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D; tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    mem_op_i = 2'b00; wd_i = 5'd4; wdata_i = 32'h55; #1;
    checks++; if (wreg_o !== 1'b1 || wd_o !== 5'd3) begin failures++; $display("FAIL b2b_first got=%b/%0d exp=1/3", wreg_o, wd_o); end
    checks++; if (wdata_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_ld_data got=%h exp=cafef00d", wdata_o); end
    tick();
    valid_i = 0; #1;
    checks++; if (wreg_o !== 1'b1 || wd_o !== 5'd4) begin failures++; $display("FAIL b2b_second got=%b/%0d exp=1/4", wreg_o, wd_o); end
    checks++; if (wdata_o !== 32'h55) begin failures++; $display("FAIL b2b_alu_data got=%h exp=00000055", wdata_o); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wreg_o === 1'b1 || mem_req_o === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL b2b_extra got=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid();
    valid_i = 1; mem_op_i = 2'b01; funct3_i = 3'b010; addr_i = 32'h600; wd_i = 5'd6; wreg_i = 1;
    tick();
    rst = 1; #1;
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rmid_req_pre got=%b exp=1", mem_req_o); end
    tick();
    rst = 0; valid_i = 0; #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rmid_req_drop got=%b exp=0", mem_req_o); end
    valid_i = 1;
    tick();
    mem_gnt_i = 1; tick();
    mem_gnt_i = 0; valid_i = 0; rst = 1; tick();
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111; #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rwait_stall got=%b exp=0", stall_o); end
    tick();
    mem_rvalid_i = 0; #1;
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL rwait_wreg got=%b exp=0", wreg_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rwait_req got=%b exp=0", mem_req_o); end
    checks++; if (wdata_o !== 32'h0) begin failures++; $display("FAIL rwait_wdata got=%h exp=0", wdata_o); end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    int reqs;
    valid_i = 1; mem_op_i = 2'b01; funct3_i = 3'b010; addr_i = 32'h2; wd_i = 5'd8; wreg_i = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", stall_o); end
    tick();
    valid_i = 0; #1;
    checks++; if (misalign_o !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", misalign_o); end
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL mis_wreg got=%b exp=0", wreg_o); end
    reqs = (mem_req_o === 1'b1) ? 1 : 0;
    tick();
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", misalign_o); end
    if (mem_req_o === 1'b1) reqs++;
    checks++; if (reqs !== 0) begin failures++; $display("FAIL mis_req got=%0d exp=0", reqs); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_alu(5'd5, 32'h0000_1234, 1'b1);
    test_alu(5'd0, 32'hDEAD_0000, 1'b0);
    test_store(3'b000, 32'h103, 32'h55AA_66AB, 4'b1000, 32'hABAB_ABAB, 2);
    test_store(3'b001, 32'h406, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 0);
    test_store(3'b010, 32'h408, 32'h0102_0304, 4'b1111, 32'h0102_0304, 1);
    test_load(3'b000, 32'h202, 32'h00F0_0000, 5'd7, 32'hFFFF_FFF0, 2);
    test_load(3'b100, 32'h202, 32'h00F0_0000, 5'd7, 32'h0000_00F0, 2);
    test_load(3'b001, 32'h302, 32'h8001_1234, 5'd10, 32'hFFFF_8001, 1);
    test_load(3'b101, 32'h300, 32'h8001_9234, 5'd11, 32'h0000_9234, 0);
    test_load(3'b010, 32'h304, 32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF, 1);
    test_back_to_back();
    test_reset_mid();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
